// File: rtl/tone_mapping_ctrl_if.sv
// Control-plane and pixel-framing bundle for tone_mapping_ctrl.
// Field mapping to the block's logical ports:
//   cfg_wr -> cfg_wr_i, cfg_enable -> cfg_enable_i, cfg_parallax -> cfg_parallax_i,
//   err_clr -> err_clr_i, sop -> sop_i, eop -> eop_i, valid -> valid_i.
// The master drives every field; the sequencer is the slave.
interface tone_mapping_ctrl_if;
  logic       cfg_wr;
  logic       cfg_enable;
  logic [7:0] cfg_parallax;
  logic       err_clr;
  logic       sop;
  logic       eop;
  logic       valid;

  modport master (
    output cfg_wr,
    output cfg_enable,
    output cfg_parallax,
    output err_clr,
    output sop,
    output eop,
    output valid
  );

  modport slave (
    input cfg_wr,
    input cfg_enable,
    input cfg_parallax,
    input err_clr,
    input sop,
    input eop,
    input valid
  );
endinterface

// File: rtl/tone_mapping_ctrl.sv
// Frame-synchronous configuration sequencer for the RGB tone-mapping wrapper.
// Config writes land in a shadow register and are applied only in IDLE, i.e. between
// frames once the datapath has drained, so the enable mux and parallax setting never
// switch mid-frame. sop/eop framing is checked and violations are kept as sticky errors.
// Optional frame/pixel statistics are built only when TM_CTRL_STATS_EN is defined;
// otherwise frame_cnt_o and pix_cnt_o are tied to zero.
module tone_mapping_ctrl #(
  parameter int unsigned DRAIN    = 21,
  parameter logic [7:0]  PAR_INIT = 8'd0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tone_mapping_ctrl_if.slave   bus_if,
  output logic                 tm_enable_o,
  output logic [7:0]           reg_parallax_corr_o,
  output logic                 pending_o,
  output logic                 update_done_o,
  output logic [1:0]           err_o,
  output logic [CNT_W-1:0]     frame_cnt_o,
  output logic [23:0]          pix_cnt_o
);

  localparam int unsigned DrainW = $clog2(DRAIN + 1);
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFrame,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [DrainW-1:0] cnt_q, cnt_d;

  logic              shadow_en_q, shadow_en_d;
  logic [7:0]        shadow_par_q, shadow_par_d;
  logic              pending_q, pending_d;

  logic              tm_en_q, tm_en_d;
  logic [7:0]        par_q, par_d;
  logic              upd_q, upd_d;
  logic [1:0]        err_q, err_d;

  logic              qsop, qeop;
  logic              apply;
  logic [1:0]        err_set;

  // sop/eop only count on valid beats.
  assign qsop = bus_if.sop & bus_if.valid;
  assign qeop = bus_if.eop & bus_if.valid;

  // Frame FSM: tracks framing, drain countdown, and decides when config may be applied.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    err_set = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (qsop && qeop) begin
          // Single-beat frame: its pixel is still in the pipeline, so drain first.
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end else if (qsop) begin
          // A starting frame beats a pending apply.
          state_d = StFrame;
        end else begin
          if (qeop) begin
            err_set[1] = 1'b1;
          end
          if (pending_q) begin
            apply = 1'b1;
          end
        end
      end
      StFrame: begin
        if (qeop) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end else if (qsop) begin
          err_set[0] = 1'b1;
        end
      end
      StDrain: begin
        if (qsop && qeop) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end else if (qsop) begin
          // Next frame arrived before the drain finished; config stays pending.
          state_d = StFrame;
        end else begin
          if (qeop) begin
            err_set[1] = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - DrainW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow, pending, applied config and sticky error next-state.
  always_comb begin
    shadow_en_d  = shadow_en_q;
    shadow_par_d = shadow_par_q;
    tm_en_d      = tm_en_q;
    par_d        = par_q;
    // A write in the apply cycle keeps pending set so the new value goes out next.
    pending_d    = bus_if.cfg_wr | (pending_q & ~apply);
    upd_d        = apply;
    if (bus_if.cfg_wr) begin
      shadow_en_d  = bus_if.cfg_enable;
      shadow_par_d = bus_if.cfg_parallax;
    end
    if (apply) begin
      tm_en_d = shadow_en_q;
      par_d   = shadow_par_q;
    end
    // Setting events win over a simultaneous clear.
    err_d = (bus_if.err_clr ? 2'b00 : err_q) | err_set;
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shadow_en_q  <= 1'b0;
      shadow_par_q <= PAR_INIT;
      pending_q    <= 1'b0;
      tm_en_q      <= 1'b0;
      par_q        <= PAR_INIT;
      upd_q        <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_en_q  <= shadow_en_d;
      shadow_par_q <= shadow_par_d;
      pending_q    <= pending_d;
      tm_en_q      <= tm_en_d;
      par_q        <= par_d;
      upd_q        <= upd_d;
      err_q        <= err_d;
    end
  end

  assign tm_enable_o         = tm_en_q;
  assign reg_parallax_corr_o = par_q;
  assign pending_o           = pending_q;
  assign update_done_o       = upd_q;
  assign err_o               = err_q;

`ifdef TM_CTRL_STATS_EN
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [23:0]      run_q, run_d;
  logic [23:0]      pix_q, pix_d;
  logic [23:0]      run_inc;
  logic             frame_close;
  logic             frame_start;

  // A frame closes on its eop in FRAME, or on a single sop+eop beat outside FRAME.
  assign frame_close = qeop & (qsop | (state_q == StFrame));
  assign frame_start = qsop & (state_q != StFrame);
  assign run_inc     = (&run_q) ? run_q : run_q + 24'(1);

  // Statistics: running beat count per frame, latched on the closing eop.
  always_comb begin
    frame_d = frame_q;
    run_d   = run_q;
    pix_d   = pix_q;
    if (frame_start) begin
      run_d = 24'(1);
    end else if ((state_q == StFrame) && bus_if.valid) begin
      run_d = run_inc;
    end
    if (frame_close) begin
      frame_d = frame_q + CNT_W'(1);
      pix_d   = frame_start ? 24'(1) : run_inc;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      run_q   <= '0;
      pix_q   <= '0;
    end else begin
      frame_q <= frame_d;
      run_q   <= run_d;
      pix_q   <= pix_d;
    end
  end

  assign frame_cnt_o = frame_q;
  assign pix_cnt_o   = pix_q;
`else
  assign frame_cnt_o = '0;
  assign pix_cnt_o   = '0;
`endif

endmodule
